// File: rtl/controller.sv
// ============================================================================
// Module   : controller
// Purpose  : Multi-cycle instruction sequencer (RSTPC/FETCH/EXEC/MEM/HALT).
//            Decodes opcode/function fields into datapath control strobes.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       instOut,
  input  logic [7:0]       funcOut,
  output logic             rstPC,
  output logic             ldPC,
  output logic             pcSel,
  output logic             branchSel,
  output logic             jumpSel,
  output logic             regSel,
  output logic             inSel,
  output logic             selDm,
  output logic             selALU,
  output logic             regWrite,
  output logic             nop,
  output logic             ldWnd,
  output logic [1:0]       wndCtrl,
  output logic             memWrite,
  output logic             memRead,
  output logic [2:0]       funcCtrl,
  output logic             halted,
  output logic [CNT_W-1:0] instCount
);

  typedef enum logic [2:0] {
    RSTPC = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           rState;
  logic [CNT_W-1:0] rCount;
  logic             wOneHot;
  logic             wIllegal;

  assign wOneHot = (funcOut != 8'h00) && ((funcOut & (funcOut - 8'd1)) == 8'h00);

  always_comb begin
    wIllegal = 1'b0;
    case (instOut)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1001,
      4'b1100, 4'b1101, 4'b1110, 4'b1111: wIllegal = 1'b0;
      4'b1000:                            wIllegal = !wOneHot;
      default:                            wIllegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rState <= RSTPC;
      rCount <= '0;
    end else begin
      case (rState)
        RSTPC:   rState <= FETCH;
        FETCH:   rState <= EXEC;
        EXEC: begin
          if (wIllegal)                rState <= HALT;
          else if (instOut == 4'b0000) rState <= MEM;
          else                         rState <= FETCH;
        end
        MEM:     rState <= FETCH;
        HALT:    rState <= HALT;
        default: rState <= RSTPC;
      endcase
      if (ldPC) rCount <= rCount + C_ONE;
    end
  end

  // EXEC strobes follow the instruction fields directly so they are valid in the same cycle.
  always_comb begin
    rstPC     = 1'b0;
    ldPC      = 1'b0;
    pcSel     = 1'b0;
    branchSel = 1'b0;
    jumpSel   = 1'b0;
    regSel    = 1'b0;
    inSel     = 1'b0;
    selDm     = 1'b0;
    selALU    = 1'b0;
    regWrite  = 1'b0;
    nop       = 1'b0;
    ldWnd     = 1'b0;
    wndCtrl   = 2'b00;
    memWrite  = 1'b0;
    memRead   = 1'b0;
    funcCtrl  = 3'b000;
    case (rState)
      RSTPC: rstPC = 1'b1;
      EXEC: begin
        case (instOut)
          4'b0000: memRead = 1'b1;
          4'b0001: begin
            memWrite = 1'b1;
            ldPC     = 1'b1;
            pcSel    = 1'b1;
          end
          4'b0010: begin
            ldPC    = 1'b1;
            jumpSel = 1'b1;
            pcSel   = 1'b1;
          end
          4'b0100: begin
            ldPC      = 1'b1;
            branchSel = 1'b1;
            pcSel     = 1'b1;
          end
          4'b1000: begin
            if (wOneHot) begin
              regSel = 1'b1;
              selALU = 1'b1;
              ldPC   = 1'b1;
              pcSel  = 1'b1;
              if (!funcOut[7]) begin
                regWrite = 1'b1;
                nop      = 1'b1;
              end
              case (funcOut)
                8'h01, 8'h02: funcCtrl = 3'b101;
                8'h04:        funcCtrl = 3'b000;
                8'h08:        funcCtrl = 3'b001;
                8'h10:        funcCtrl = 3'b010;
                8'h20:        funcCtrl = 3'b011;
                8'h40:        funcCtrl = 3'b100;
                default:      funcCtrl = 3'b000;
              endcase
            end
          end
          4'b1001: begin
            ldWnd   = 1'b1;
            wndCtrl = funcOut[1:0];
            ldPC    = 1'b1;
            pcSel   = 1'b1;
          end
          4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
            inSel    = 1'b1;
            selALU   = 1'b1;
            regWrite = 1'b1;
            nop      = 1'b1;
            funcCtrl = {1'b0, instOut[1:0]};
            ldPC     = 1'b1;
            pcSel    = 1'b1;
          end
          default: ;
        endcase
      end
      MEM: begin
        memRead  = 1'b1;
        selDm    = 1'b1;
        regWrite = 1'b1;
        nop      = 1'b1;
        ldPC     = 1'b1;
        pcSel    = 1'b1;
      end
      default: ;
    endcase
  end

  assign halted    = (rState == HALT);
  assign instCount = rCount;

endmodule

`default_nettype wire

// File: tb/tb_controller.sv
// Randomized scoreboard bench for controller: driver pushes per-cycle expected
// outputs from an instruction-level model; a negedge monitor pops and compares.
`default_nettype none

module tb_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       instOut = 4'h0;
  logic [7:0]       funcOut = 8'h00;
  logic             rstPC, ldPC, pcSel, branchSel, jumpSel;
  logic             regSel, inSel, selDm, selALU, regWrite, nop;
  logic             ldWnd, memWrite, memRead, halted;
  logic [1:0]       wndCtrl;
  logic [2:0]       funcCtrl;
  logic [CNT_W-1:0] instCount;

  controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instOut(instOut), .funcOut(funcOut),
    .rstPC(rstPC), .ldPC(ldPC), .pcSel(pcSel), .branchSel(branchSel),
    .jumpSel(jumpSel), .regSel(regSel), .inSel(inSel), .selDm(selDm),
    .selALU(selALU), .regWrite(regWrite), .nop(nop), .ldWnd(ldWnd),
    .wndCtrl(wndCtrl), .memWrite(memWrite), .memRead(memRead),
    .funcCtrl(funcCtrl), .halted(halted), .instCount(instCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm;
    logic selALU, regWrite, nop, ldWnd;
    logic [1:0] wndCtrl;
    logic memWrite, memRead;
    logic [2:0] funcCtrl;
    logic halted;
    logic [CNT_W-1:0] cnt;
  } outs_t;

  outs_t q[$];
  int    checks = 0;
  int    errors = 0;
  int    modelCnt = 0;

  // Reference decode table for the EXEC cycle of one instruction.
  function automatic outs_t execVec(input logic [3:0] op, input logic [7:0] fn);
    outs_t e = '0;
    int idx = 0;
    case (op)
      4'h0: e.memRead = 1'b1;
      4'h1: begin e.memWrite = 1'b1; e.ldPC = 1'b1; e.pcSel = 1'b1; end
      4'h2: begin e.jumpSel = 1'b1; e.ldPC = 1'b1; e.pcSel = 1'b1; end
      4'h4: begin e.branchSel = 1'b1; e.ldPC = 1'b1; e.pcSel = 1'b1; end
      4'h8: if ($countones(fn) == 1) begin
        e.regSel = 1'b1; e.selALU = 1'b1; e.ldPC = 1'b1; e.pcSel = 1'b1;
        if (fn != 8'h80) begin
          e.regWrite = 1'b1; e.nop = 1'b1;
          for (int i = 0; i < 7; i++) if (fn[i]) idx = i;
          e.funcCtrl = (idx < 2) ? 3'd5 : 3'(idx - 2);
        end
      end
      4'h9: begin e.ldWnd = 1'b1; e.wndCtrl = fn[1:0]; e.ldPC = 1'b1; e.pcSel = 1'b1; end
      4'hC, 4'hD, 4'hE, 4'hF: begin
        e.inSel = 1'b1; e.selALU = 1'b1; e.regWrite = 1'b1; e.nop = 1'b1;
        e.funcCtrl = 3'(op - 4'd12); e.ldPC = 1'b1; e.pcSel = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic bit isLegal(input logic [3:0] op, input logic [7:0] fn);
    case (op)
      4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF: return 1'b1;
      4'h8: return $countones(fn) == 1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic pushCur(input outs_t e);
    e.cnt = CNT_W'(modelCnt);
    q.push_back(e);
    if (e.ldPC) modelCnt = (modelCnt + 1) % (1 << CNT_W);
  endtask

  task automatic step(input outs_t e);
    @(posedge clk);
    #1;
    pushCur(e);
  endtask

  // Assert reset now (mid-cycle), hold two edges, release.
  task automatic resetNow();
    outs_t r = '0;
    r.rstPC = 1'b1;
    rst = 1'b1;
    modelCnt = 0;
    pushCur(r);
    step(r);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushCur(r);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    resetNow();
  endtask

  task automatic runInst(input logic [3:0] op, input logic [7:0] fn, input bit rstInMem);
    outs_t h = '0;
    outs_t m = '0;
    step('0);
    instOut = op;
    funcOut = fn;
    step(execVec(op, fn));
    if (!isLegal(op, fn)) begin
      h.halted = 1'b1;
      repeat (3) step(h);
      doReset();
    end else if (op == 4'h0) begin
      if (rstInMem) begin
        @(posedge clk);
        #1;
        resetNow();
      end else begin
        m.memRead = 1'b1; m.selDm = 1'b1; m.regWrite = 1'b1;
        m.nop = 1'b1; m.ldPC = 1'b1; m.pcSel = 1'b1;
        step(m);
      end
    end
  endtask

  always @(negedge clk) begin
    outs_t e;
    outs_t a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = {rstPC, ldPC, pcSel, branchSel, jumpSel, regSel, inSel, selDm,
           selALU, regWrite, nop, ldWnd, wndCtrl, memWrite, memRead,
           funcCtrl, halted, instCount};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outs @%0t: actual=%h required=%h", $time, a, e);
      end
    end
  end

  logic [3:0] legalOps [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};

  initial begin
    logic [3:0] op;
    logic [7:0] fn;
    int r;
    doReset();
    runInst(4'hC, 8'h5A, 1'b0);
    runInst(4'h0, 8'h00, 1'b0);
    runInst(4'h8, 8'h80, 1'b0);
    runInst(4'h9, 8'h02, 1'b0);
    runInst(4'h2, 8'h00, 1'b0);
    runInst(4'h4, 8'h00, 1'b0);
    runInst(4'h8, 8'h01, 1'b0);
    runInst(4'h8, 8'h40, 1'b0);
    runInst(4'h8, 8'h0C, 1'b0);
    runInst(4'hC, 8'h00, 1'b0);
    runInst(4'h0, 8'h00, 1'b1);
    runInst(4'h8, 8'h00, 1'b0);
    runInst(4'h3, 8'h00, 1'b0);
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      if (r < 10)      op = legalOps[r];
      else if (r < 16) op = 4'h8;
      else             op = 4'($urandom_range(0, 15));
      if (op == 4'h8 && $urandom_range(0, 7) != 0) fn = 8'(1 << $urandom_range(0, 7));
      else                                         fn = 8'($urandom);
      runInst(op, fn, (op == 4'h0) && ($urandom_range(0, 9) == 0));
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual=%0d pending required=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
